data_mem_ctrl: RTL

Data-memory controller directly downstream of the core's data port. It accepts load/store requests over a valid/ready handshake and performs byte-enabled writes into an internal synchronous RAM. Reads return the full aligned 32-bit word over a second valid/ready handshake after a configurable number of wait states; lane extraction and sign extension stay in the core's load/store unit.

---
 rtl/data_mem_ctrl_pkg.sv | 11 +
 rtl/data_mem_ctrl_if.sv | 27 ++
 rtl/data_mem_ctrl_sram_be.sv | 23 ++
 rtl/data_mem_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller slice.
package data_mem_ctrl_pkg;
  localparam int unsigned DATAWIDTH = 32;
  localparam int unsigned LANES     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } dmcState_t;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side request/response bus of the data-memory controller.
interface data_mem_ctrl_if;
  import data_mem_ctrl_pkg::*;

  logic                 DMC_Req_Valid_In;
  logic                 DMC_Req_Ready_Out;
  logic                 DMC_Req_Write_In;
  logic [31:0]          DMC_Req_Addr_InBUS;
  logic [LANES-1:0]     DMC_Req_Byteenable_InBUS;
  logic [DATAWIDTH-1:0] DMC_Req_Writedata_InBUS;
  logic                 DMC_Rsp_Valid_Out;
  logic                 DMC_Rsp_Ready_In;
  logic [DATAWIDTH-1:0] DMC_Rsp_Readdata_OutBUS;
  logic                 DMC_Err_Out;

  modport master (
    output DMC_Req_Valid_In, DMC_Req_Write_In, DMC_Req_Addr_InBUS,
           DMC_Req_Byteenable_InBUS, DMC_Req_Writedata_InBUS, DMC_Rsp_Ready_In,
    input  DMC_Req_Ready_Out, DMC_Rsp_Valid_Out, DMC_Rsp_Readdata_OutBUS, DMC_Err_Out
  );

  modport slave (
    input  DMC_Req_Valid_In, DMC_Req_Write_In, DMC_Req_Addr_InBUS,
           DMC_Req_Byteenable_InBUS, DMC_Req_Writedata_InBUS, DMC_Rsp_Ready_In,
    output DMC_Req_Ready_Out, DMC_Rsp_Valid_Out, DMC_Rsp_Readdata_OutBUS, DMC_Err_Out
  );
endinterface

// File: rtl/data_mem_ctrl_sram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module sram_be
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic                 clk,
  input  logic [LANES-1:0]     wrEn,
  input  logic                 rdEn,
  input  logic [AW-1:0]        addr,
  input  logic [DATAWIDTH-1:0] wdata,
  output logic [DATAWIDTH-1:0] rdata
);
  logic [DATAWIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wrEn[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (rdEn) rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: request FSM, wait-state counter, range check and
// response/error signalling in front of a byte-enabled synchronous RAM.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            DMC_Clk_In,
  input  logic            DMC_Reset_In,
  data_mem_ctrl_if.slave  bus
);
  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

  dmcState_t            state, stateNext;
  logic [2:0]           waitCnt, waitCntNext;
  logic                 loadErr, loadErrNext;
  logic                 storeErr, storeErrNext;
  logic [AW-1:0]        wordIdx;
  logic [31:0]          upperBits;
  logic [1:0]           unusedAddrLsb;
  logic                 outOfRange, accept, isStore;
  logic [LANES-1:0]     ramWrEn;
  logic                 ramRdEn;
  logic [DATAWIDTH-1:0] ramRdata;

  assign wordIdx       = bus.DMC_Req_Addr_InBUS[AW+1:2];
  assign upperBits     = bus.DMC_Req_Addr_InBUS >> (AW + 2);
  assign unusedAddrLsb = bus.DMC_Req_Addr_InBUS[1:0];
  assign outOfRange    = (upperBits != '0) || (32'(wordIdx) >= MEM_WORDS);
  assign accept        = bus.DMC_Req_Valid_In && (state == IDLE);
  assign isStore       = bus.DMC_Req_Write_In;
  assign ramWrEn       = (accept && isStore && !outOfRange) ? bus.DMC_Req_Byteenable_InBUS : '0;
  assign ramRdEn       = accept && !isStore && !outOfRange;

  sram_be #(.MEM_WORDS(MEM_WORDS), .AW(AW)) uRam (
    .clk   (DMC_Clk_In),
    .wrEn  (ramWrEn),
    .rdEn  (ramRdEn),
    .addr  (wordIdx),
    .wdata (bus.DMC_Req_Writedata_InBUS),
    .rdata (ramRdata)
  );

  always_comb begin
    stateNext    = state;
    waitCntNext  = waitCnt;
    loadErrNext  = loadErr;
    storeErrNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (isStore) begin
            storeErrNext = outOfRange;
          end else begin
            loadErrNext = outOfRange;
            if (WAIT_INIT == 3'd0) begin
              stateNext = RSP;
            end else begin
              stateNext   = RD_WAIT;
              waitCntNext = WAIT_INIT;
            end
          end
        end
      end
      RD_WAIT: begin
        waitCntNext = waitCnt - 3'd1;
        if (waitCnt == 3'd1) stateNext = RSP;
      end
      RSP: begin
        if (bus.DMC_Rsp_Ready_In) begin
          stateNext   = IDLE;
          loadErrNext = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge DMC_Clk_In or negedge DMC_Reset_In) begin
    if (!DMC_Reset_In) begin
      state    <= IDLE;
      waitCnt  <= '0;
      loadErr  <= 1'b0;
      storeErr <= 1'b0;
    end else begin
      state    <= stateNext;
      waitCnt  <= waitCntNext;
      loadErr  <= loadErrNext;
      storeErr <= storeErrNext;
    end
  end

  // The RAM read register doubles as the response register: it is only
  // loaded at load acceptance, so it stays stable for the whole RSP interval.
  assign bus.DMC_Req_Ready_Out       = (state == IDLE);
  assign bus.DMC_Rsp_Valid_Out       = (state == RSP);
  assign bus.DMC_Rsp_Readdata_OutBUS = ((state == RSP) && !loadErr) ? ramRdata : '0;
  assign bus.DMC_Err_Out             = storeErr || ((state == RSP) && loadErr);
endmodule
